// File: rtl/jk_pkg.sv
// jk_pkg: shared mode encodings for the JK register bank
package jk_pkg;
  typedef enum logic [1:0] {
    MODE_JK = 2'b00,
    MODE_SR = 2'b01,
    MODE_D  = 2'b10,
    MODE_T  = 2'b11
  } mode_e;
endpackage

// File: rtl/jk_cell.sv
// jk_cell: next-state and SR-conflict detection for one flip-flop channel
import jk_pkg::*;
module jk_cell (
  input  mode_e mode_i,
  input  logic  j_i,
  input  logic  k_i,
  input  logic  q_i,
  output logic  next_q_o,
  output logic  illegal_hit_o
);
  // J=K=1 toggles in JK mode but holds (and flags) in SR mode; D and T ignore K
  always_comb begin
    illegal_hit_o = (mode_i == MODE_SR) && j_i && k_i;
    next_q_o = (mode_i == MODE_D) ? j_i :
               (mode_i == MODE_T) ? (q_i ^ j_i) :
               (j_i && k_i) ? ((mode_i == MODE_JK) ? ~q_i : q_i) :
               j_i ? 1'b1 :
               k_i ? 1'b0 : q_i;
  end
endmodule

// File: rtl/jk_reg_bank.sv
// jk_reg_bank: WIDTH-channel JK/SR/D/T register bank with load, change strobes and sticky SR-conflict flags
import jk_pkg::*;
module jk_reg_bank #(
  parameter int unsigned WIDTH = 8,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             Clk,
  input  logic             Clear,
  input  logic             Enable,
  input  logic [1:0]       Mode,
  input  logic [WIDTH-1:0] J,
  input  logic [WIDTH-1:0] K,
  input  logic             Load,
  input  logic [WIDTH-1:0] LoadData,
  input  logic             ErrClr,
  output logic [WIDTH-1:0] Q,
  output logic [WIDTH-1:0] Qbar,
  output logic [WIDTH-1:0] Changed,
  output logic [WIDTH-1:0] Illegal
);
  logic [WIDTH-1:0] q_q, changed_q, illegal_q;
  logic [WIDTH-1:0] q_d, illegal_d, cell_next, cell_hit;

  for (genvar g = 0; g < WIDTH; g++) begin : g_cell
    jk_cell u_cell (
      .mode_i       (mode_e'(Mode)),
      .j_i          (J[g]),
      .k_i          (K[g]),
      .q_i          (q_q[g]),
      .next_q_o     (cell_next[g]),
      .illegal_hit_o(cell_hit[g])
    );
  end

  // Load beats the per-channel update; a new SR conflict beats ErrClr
  always_comb begin
    q_d       = Load ? LoadData : (Enable ? cell_next : q_q);
    illegal_d = (ErrClr ? '0 : illegal_q) | ((Enable && !Load) ? cell_hit : '0);
  end

  // Clear overrides everything; Changed marks bits whose value moves at this edge
  always_ff @(posedge Clk) begin
    if (!Clear) begin
      q_q       <= RESET_VAL;
      changed_q <= '0;
      illegal_q <= '0;
    end else begin
      q_q       <= q_d;
      changed_q <= q_d ^ q_q;
      illegal_q <= illegal_d;
    end
  end

  assign Q       = q_q;
  assign Qbar    = ~q_q;
  assign Changed = changed_q;
  assign Illegal = illegal_q;
endmodule

// File: tb/tb_jk_reg_bank.sv
// tb_jk_reg_bank: directed test plan plus randomized run against a behavioural model
module tb_jk_reg_bank;
  localparam int W = 4;
  logic Clk = 1'b0;
  logic Clear = 1'b1, Enable = 1'b0, Load = 1'b0, ErrClr = 1'b0;
  logic [1:0] Mode = 2'b00;
  logic [W-1:0] J = '0, K = '0, LoadData = '0;
  logic [W-1:0] Q, Qbar, Changed, Illegal;
  int checks = 0, failures = 0;
  bit mq[W], mch[W], mil[W];
  bit valid = 0;

  jk_reg_bank #(.WIDTH(W), .RESET_VAL(4'h0)) dut (
    .Clk(Clk), .Clear(Clear), .Enable(Enable), .Mode(Mode), .J(J), .K(K),
    .Load(Load), .LoadData(LoadData), .ErrClr(ErrClr),
    .Q(Q), .Qbar(Qbar), .Changed(Changed), .Illegal(Illegal)
  );

  always #5 Clk = ~Clk;

  function automatic logic [W-1:0] pack(input bit a[W]);
    logic [W-1:0] r;
    for (int i = 0; i < W; i++) r[i] = a[i];
    return r;
  endfunction

  // behavioural model: per-bit rules written as tables of the mode semantics
  always @(posedge Clk) begin
    bit nq;
    int jk;
    if (!Clear) begin
      for (int i = 0; i < W; i++) begin mq[i] = 0; mch[i] = 0; mil[i] = 0; end
      valid = 1;
    end else begin
      for (int i = 0; i < W; i++) begin
        jk = 2 * int'(J[i]) + int'(K[i]);
        nq = mq[i];
        if (Load) nq = LoadData[i];
        else if (Enable) begin
          case (Mode)
            2'd0: nq = (jk == 0) ? mq[i] : (jk == 1) ? 1'b0 : (jk == 2) ? 1'b1 : !mq[i];
            2'd1: nq = (jk == 1) ? 1'b0 : (jk == 2) ? 1'b1 : mq[i];
            2'd2: nq = J[i];
            default: nq = J[i] ? !mq[i] : mq[i];
          endcase
        end
        if (ErrClr) mil[i] = 0;
        if (!Load && Enable && Mode == 2'd1 && jk == 3) mil[i] = 1;
        mch[i] = (nq != mq[i]);
        mq[i] = nq;
      end
    end
  end

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  // compare process: every falling edge once the model is meaningful
  always @(negedge Clk) if (valid) begin
    chk("q_model", Q, pack(mq));
    chk("qbar_model", Qbar, ~pack(mq));
    chk("changed_model", Changed, pack(mch));
    chk("illegal_model", Illegal, pack(mil));
  end

  task automatic cyc(input logic c, input logic e, input logic [1:0] m, input logic [W-1:0] j,
                     input logic [W-1:0] k, input logic l, input logic [W-1:0] ld, input logic ec);
    @(negedge Clk);
    #1;
    Clear = c; Enable = e; Mode = m; J = j; K = k; Load = l; LoadData = ld; ErrClr = ec;
    @(posedge Clk);
    #1;
  endtask

  initial begin
    cyc(0, 0, 0, 0, 0, 1, 4'hF, 1);
    chk("reset_q", Q, 4'h0); chk("reset_qbar", Qbar, 4'hF);
    chk("reset_changed", Changed, 4'h0); chk("reset_illegal", Illegal, 4'h0);
    cyc(1, 0, 0, 0, 0, 1, 4'b0011, 0);
    cyc(1, 1, 0, 4'b1010, 4'b0110, 0, 0, 0);
    chk("jk_q", Q, 4'b1001); chk("jk_changed", Changed, 4'b1010);
    cyc(1, 1, 0, 0, 0, 0, 0, 0);
    chk("jk_hold_q", Q, 4'b1001); chk("jk_hold_changed", Changed, 4'b0000);
    cyc(1, 0, 0, 0, 0, 1, 4'b0101, 0);
    cyc(1, 1, 1, 4'b1100, 4'b1010, 0, 0, 0);
    chk("sr_q", Q, 4'b0101); chk("sr_illegal", Illegal, 4'b1000);
    cyc(1, 1, 1, 4'b1000, 4'b1000, 0, 0, 1);
    chk("sr_setwins", Illegal, 4'b1000);
    cyc(1, 1, 1, 0, 0, 0, 0, 1);
    chk("sr_errclr", Illegal, 4'b0000);
    cyc(1, 1, 2, 4'b0110, 4'b1001, 0, 0, 0);
    chk("d_q", Q, 4'b0110);
    cyc(1, 1, 3, 4'hF, 0, 0, 0, 0);
    chk("t1_q", Q, 4'b1001); chk("t1_changed", Changed, 4'hF);
    cyc(1, 1, 3, 4'hF, 0, 0, 0, 0);
    chk("t2_q", Q, 4'b0110); chk("t2_changed", Changed, 4'hF);
    cyc(1, 0, 3, 4'hF, 0, 1, 4'hA, 0);
    chk("load_q", Q, 4'hA);
    cyc(1, 0, 3, 4'hF, 0, 0, 0, 0);
    chk("hold_q", Q, 4'hA); chk("hold_changed", Changed, 4'h0);
    cyc(1, 1, 3, 4'hF, 0, 0, 0, 0);
    chk("pre_rst_q", Q, 4'h5);
    cyc(0, 1, 3, 4'hF, 0, 1, 4'h7, 1);
    chk("midrst_q", Q, 4'h0); chk("midrst_changed", Changed, 4'h0);
    cyc(1, 1, 3, 4'hF, 0, 0, 0, 0);
    chk("resume_q", Q, 4'hF); chk("resume_changed", Changed, 4'hF);
    for (int n = 0; n < 400; n++)
      cyc(($urandom_range(0, 31) != 0), ($urandom_range(0, 3) != 0), 2'($urandom_range(0, 3)),
          4'($urandom), 4'($urandom), ($urandom_range(0, 7) == 0), 4'($urandom),
          ($urandom_range(0, 5) == 0));
    @(negedge Clk);
    #1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/jk_reg_bank.md
Name: jk_reg_bank

Overview:
- Parametrised bank of WIDTH edge-triggered JK-family flip-flops on one clock; the clocked, multi-bit successor of the single-bit JK latch.
- Supports four per-bank operating modes: JK, SR, D and T.
- Also provides parallel load, per-bit change strobes and sticky illegal-input flags for SR mode.
- Used as a general state/flag register in control paths that need set/reset/toggle semantics without glue logic.

Parameters:
- WIDTH, 8, number of flip-flop channels (1..32).
- RESET_VAL, {WIDTH{1'b0}}, value loaded into Q on Clear.

Ports:
- Clk  in  1  clock; all state updates on rising edge.
- Clear  in  1  reset, synchronous, active-low; sampled on rising Clk.
- Enable  in  1  update enable; 0 = hold all channels.
- Mode  in  2  00 JK, 01 SR, 10 D, 11 T (applies to all channels).
- J  in  WIDTH  J / S / D / T input per channel.
- K  in  WIDTH  K / R input per channel; ignored in D and T modes.
- Load  in  1  parallel load strobe.
- LoadData  in  WIDTH  value written to Q on Load.
- ErrClr  in  1  clears all Illegal flags.
- Q  out  WIDTH  registered state.
- Qbar  out  WIDTH  always bitwise ~Q (combinational from Q; never X, never equal to Q).
- Changed  out  WIDTH  registered; bit i = 1 for exactly the cycle after an edge where Q[i] changed value.
- Illegal  out  WIDTH  sticky; bit i set when SR mode sees S=R=1 on channel i while enabled.

Behaviour:
- Clock and reset: one clock Clk; reset Clear is synchronous, active-low.
- Reset (Clear=0 at rising Clk):
  - Q=RESET_VAL, Qbar=~RESET_VAL.
  - Changed=0, Illegal=0.
  - All other inputs are ignored that cycle.
- Priority per rising edge: Clear > Load > Enable-driven update > hold.
- Load=1:
  - Q<=LoadData regardless of Enable and Mode.
  - No Illegal update that cycle.
- Enable=1, Load=0, per channel i, next Q[i]:
  - JK mode: 00 hold; 10 set; 01 reset; 11 toggle (~Q[i]). Unlike the old latch, no X.
  - SR mode: 00 hold; 10 set; 01 reset; 11 hold Q[i] and set Illegal[i].
  - D mode: Q[i]<=J[i].
  - T mode: J[i]=1 toggles, J[i]=0 holds.
- Enable=0, Load=0: all Q hold, Illegal holds (except ErrClr).
- Changed:
  - Registered as Changed[i] <= (next_Q[i] != Q[i]) each non-reset edge.
  - Width-1 pulse aligned with the new Q value being visible.
  - A held bit gives 0.
- Illegal / ErrClr:
  - ErrClr=1 clears all Illegal bits at the edge.
  - If ErrClr coincides with a new SR 11 on channel i, Illegal[i] ends at 1 (set wins over clear).
- Latency: one Clk from input sample to Q / Changed / Illegal.
- Mode change: takes effect on the same edge it is sampled. No internal mode state; no pipeline to flush.
- Reset mid-operation: Clear overrides a simultaneous Load / ErrClr / update; outputs take reset values at that edge.
- X handling: inputs are assumed 2-state. The design must not generate X internally on any legal Mode.

Decomposition:
- Shared package jk_pkg:
  - Mode encodings MODE_JK=2'b00, MODE_SR=2'b01, MODE_D=2'b10, MODE_T=2'b11.
  - Mode typedef.
- Sub-module jk_cell (single channel):
  - Inputs: Mode, J, K, Q. Outputs: next_q, illegal_hit.
  - Combinational.
  - Instantiated WIDTH times via generate.
- Top holds the Q / Changed / Illegal registers, priority logic and Qbar.

Test Plan (WIDTH=4, RESET_VAL=0):
1. Clear=0 one edge with Load=1, LoadData=4'hF, ErrClr=1 -> Q=4'h0, Qbar=4'hF, Changed=0, Illegal=0.
2. JK, Enable=1, J=4'b1010, K=4'b0110 from Q=4'b0011 -> Q=4'b1001 (toggle, set, reset, hold per bit), Changed=4'b1010. Next edge J=K=0 -> Q holds, Changed=0.
3. SR, Q=4'b0101, J=4'b1100, K=4'b1010 -> Q=4'b0101, Illegal=4'b1000. Then ErrClr=1 with J=4'b1000, K=4'b1000 -> Illegal stays 4'b1000. Next ErrClr=1, J=K=0 -> Illegal=0.
4. D then T:
   - D, J=4'b0110 -> Q=4'b0110.
   - T, J=4'b1111 twice -> Q=4'b1001, then 4'b0110, Changed=4'hF each cycle.
5. Load=1, LoadData=4'hA, Enable=0, Mode=T, J=4'hF -> Q=4'hA. Then Enable=0, Load=0 -> Q holds 4'hA, Changed=0.
6. Reset mid-sequence: T mode toggling every cycle, assert Clear=0 one edge -> Q=0, Changed=0. Deassert -> toggling resumes from 0 next edge (Q=4'hF).
